demod_ctrl: RTL and testbench

Sequencer for the FM demodulator datapath (byte merge → conjugate multiply → 128-sample average → 17-tap FIR → byte split). Counts UART bytes into IQ samples and issues one-cycle stage enables. Primes and drains the pipeline around each frame, decimates by DECIM, and presents each demodulated word to the byte splitter through a valid/ready handshake. Sits between the UART receiver and the datapath, replacing the free-running `start_i`/`merge_finished` wiring.

---
 rtl/demod_pkg.sv | 16 +
 rtl/mod_counter.sv | 27 ++
 rtl/demod_ctrl.sv | 107 ++++++++++
 tb/tb_demod_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// demod_pkg: shared state type, default sequencing constants and counter width helper for demod_ctrl
package demod_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} ctrl_state_t;

    localparam int BYTES_PER_SAMPLE = 4;
    localparam int DECIM            = 128;
    localparam int PIPE_LAT         = 7;
    localparam int FRAME_SAMPLES    = 4096;
    localparam int DATA_W           = 16;

    function automatic int cnt_w(input int m);
        return m > 1 ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD counter; clr restarts from zero and still honours en in the same cycle
module mod_counter
    import demod_pkg::*;
#(
    parameter int MOD = 2,
    localparam int W = cnt_w(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] base;

    assign base = clr ? '0 : count;
    assign wrap = en && base == W'(MOD - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else
            count <= wrap ? '0 : base + W'(en);

endmodule

// File: rtl/demod_ctrl.sv
// demod_ctrl: FM demodulator sequencer; DEMOD_CTRL_STATS_EN adds frame_cnt_o/ovr_cnt_o counters
module demod_ctrl #(
    parameter int BYTES_PER_SAMPLE = demod_pkg::BYTES_PER_SAMPLE,
    parameter int DECIM            = demod_pkg::DECIM,
    parameter int PIPE_LAT         = demod_pkg::PIPE_LAT,
    parameter int FRAME_SAMPLES    = demod_pkg::FRAME_SAMPLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        byte_valid_i,
    output logic        sample_en_o,
    output logic        flush_o,
    output logic        dec_load_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        overrun_o
`ifdef DEMOD_CTRL_STATS_EN
    ,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] ovr_cnt_o
`endif
);

    import demod_pkg::*;

    localparam int BW = cnt_w(BYTES_PER_SAMPLE);
    localparam int PW = cnt_w(PIPE_LAT);
    localparam int FW = cnt_w(FRAME_SAMPLES);
    localparam int DW = cnt_w(DECIM);

    ctrl_state_t state, state_d;
    logic [BW-1:0] byte_cnt;
    logic [PW-1:0] pc_cnt;
    logic [FW-1:0] fr_cnt;
    logic [DW-1:0] dec_cnt;
    logic byte_acc, byte_wrap, pc_clr, pc_en, pc_wrap, fr_en, fr_wrap, dec_en, dec_wrap;
    logic sample_en_d, dec_load_d, ovr_evt, unused;

    assign byte_acc = byte_valid_i && (start_i || state == FILL || state == RUN);
    assign fr_en    = sample_en_o && !start_i && (state == FILL || state == RUN);
    assign dec_en   = sample_en_o && !start_i && (state == RUN || state == FLUSH);
    // fill/flush share one counter; frame end restarts it so FLUSH always drains PIPE_LAT strobes
    assign pc_clr   = start_i || fr_wrap;
    assign pc_en    = sample_en_o && !pc_clr && (state == FILL || state == FLUSH);

    assign state_d = start_i ? FILL :
                     fr_wrap ? FLUSH :
                     pc_wrap ? (state == FILL ? RUN : IDLE) : state;

    assign sample_en_d = byte_wrap || state_d == FLUSH;
    // load is registered, so look one strobe ahead of the decimation counter
    assign dec_load_d  = sample_en_d && (state_d == RUN || state_d == FLUSH) &&
                         dec_cnt == (dec_en ? DW'(DECIM - 2) : DW'(DECIM - 1));
    assign ovr_evt     = dec_load_o && out_valid_o && !out_ready_i;
    assign unused      = ^{byte_cnt, pc_cnt, fr_cnt, dec_wrap};

    mod_counter #(.MOD(BYTES_PER_SAMPLE)) u_byte (
        .clk(clk), .rst(rst), .clr(start_i), .en(byte_acc), .count(byte_cnt), .wrap(byte_wrap)
    );

    mod_counter #(.MOD(PIPE_LAT)) u_pipe (
        .clk(clk), .rst(rst), .clr(pc_clr), .en(pc_en), .count(pc_cnt), .wrap(pc_wrap)
    );

    mod_counter #(.MOD(FRAME_SAMPLES)) u_frame (
        .clk(clk), .rst(rst), .clr(start_i), .en(fr_en), .count(fr_cnt), .wrap(fr_wrap)
    );

    mod_counter #(.MOD(DECIM)) u_dec (
        .clk(clk), .rst(rst), .clr(start_i), .en(dec_en), .count(dec_cnt), .wrap(dec_wrap)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            sample_en_o <= 1'b0;
            flush_o     <= 1'b0;
            dec_load_o  <= 1'b0;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            state       <= state_d;
            sample_en_o <= sample_en_d;
            flush_o     <= state_d == FLUSH;
            dec_load_o  <= dec_load_d;
            busy_o      <= state_d != IDLE;
            out_valid_o <= !start_i && (dec_load_o || (out_valid_o && !out_ready_i));
            overrun_o   <= !start_i && (overrun_o || ovr_evt);
        end

`ifdef DEMOD_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            frame_cnt_o <= '0;
            ovr_cnt_o   <= '0;
        end else begin
            if (state == FLUSH && state_d == IDLE && frame_cnt_o != 16'hFFFF)
                frame_cnt_o <= frame_cnt_o + 16'd1;
            if (ovr_evt && !start_i && ovr_cnt_o != 16'hFFFF)
                ovr_cnt_o <= ovr_cnt_o + 16'd1;
        end
`endif

endmodule

// File: tb/tb_demod_ctrl.sv
// tb_demod_ctrl: directed bench for demod_ctrl with DECIM=4, PIPE_LAT=2, FRAME_SAMPLES=10
module tb_demod_ctrl;

    logic clk, rst, start_i, byte_valid_i, out_ready_i;
    logic sample_en_o, flush_o, dec_load_o, out_valid_o, busy_o, overrun_o;
    logic [5:0] outs;
`ifdef DEMOD_CTRL_STATS_EN
    logic [15:0] frame_cnt_o, ovr_cnt_o;
`endif
    int checks = 0;
    int passed = 0;
    int fails = 0;

    demod_ctrl #(
        .BYTES_PER_SAMPLE(4),
        .DECIM(4),
        .PIPE_LAT(2),
        .FRAME_SAMPLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .byte_valid_i(byte_valid_i),
        .sample_en_o(sample_en_o),
        .flush_o(flush_o),
        .dec_load_o(dec_load_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o(busy_o),
        .overrun_o(overrun_o)
`ifdef DEMOD_CTRL_STATS_EN
        ,
        .frame_cnt_o(frame_cnt_o),
        .ovr_cnt_o(ovr_cnt_o)
`endif
    );

    assign outs = {sample_en_o, flush_o, dec_load_o, out_valid_o, busy_o, overrun_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input logic rdy);
        out_ready_i = rdy;
        byte_valid_i = 1'b0;
        tick();
    endtask

    task automatic send_bytes(input string tag, input int n, input logic exp_se, input logic exp_ld);
        for (int i = 0; i < n; i++) begin
            byte_valid_i = 1'b1;
            tick();
            if (i < n - 1)
                chk({tag, "_se_mid"}, 16'(sample_en_o), 16'd0);
        end
        byte_valid_i = 1'b0;
        chk({tag, "_se"}, 16'(sample_en_o), 16'(exp_se));
        chk({tag, "_load"}, 16'(dec_load_o), 16'(exp_ld));
    endtask

    task automatic frame_start(input string tag);
        start_i = 1'b1;
        byte_valid_i = 1'b1;
        tick();
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        chk({tag, "_start"}, 16'(outs), 16'b000010);
        send_bytes({tag, "_fill0"}, 3, 1'b1, 1'b0);
        send_bytes({tag, "_fill1"}, 4, 1'b1, 1'b0);
        gap(out_ready_i);
    endtask

    task automatic post(input string tag, input logic ld, input logic rdy, input logic [1:0] exp_vo);
        send_bytes(tag, 4, 1'b1, ld);
        gap(rdy);
        chk({tag, "_vld_ovr"}, 16'({out_valid_o, overrun_o}), 16'(exp_vo));
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        chk("rst_hold", 16'(outs), 16'd0);
        rst = 1'b0;
        tick();
        chk("rst_idle", 16'(outs), 16'd0);

        // frame 1: ready always high, one-cycle valid after each load
        frame_start("f1");
        chk("f1_fill_flush", 16'(flush_o), 16'd0);
        for (int k = 1; k <= 8; k++)
            post($sformatf("f1_p%0d", k), k % 4 == 0, 1'b1, {k % 4 == 0, 1'b0});
        chk("f1_fl1", 16'({sample_en_o, flush_o, busy_o}), 16'b111);
        gap(1'b1);
        chk("f1_fl2", 16'({sample_en_o, flush_o, out_valid_o}), 16'b110);
        gap(1'b1);
        chk("f1_done", 16'({sample_en_o, flush_o, busy_o}), 16'd0);
        send_bytes("f1_idle", 4, 1'b0, 1'b0);
        chk("f1_idle_busy", 16'(busy_o), 16'd0);

        // frame 2: ready low, second load overruns
        out_ready_i = 1'b0;
        frame_start("f2");
        for (int k = 1; k <= 8; k++)
            post($sformatf("f2_p%0d", k), k % 4 == 0, 1'b0, {k >= 4, k == 8});
        chk("f2_fl1", 16'({sample_en_o, flush_o}), 16'b11);
        gap(1'b0);
        gap(1'b0);
        chk("f2_done", 16'({busy_o, out_valid_o, overrun_o}), 16'b011);

        // frame 3: ready raised only in the second load cycle
        frame_start("f3");
        for (int k = 1; k <= 8; k++)
            post($sformatf("f3_p%0d", k), k % 4 == 0, k == 8, {k >= 4, 1'b0});
        chk("f3_fl1", 16'(flush_o), 16'd1);
        gap(1'b1);
        chk("f3_fl2_vld", 16'(out_valid_o), 16'd0);
        gap(1'b1);
        chk("f3_done", 16'(busy_o), 16'd0);

        // frame 4: restart mid-RUN on a byte, with a pending word and half a sample
        out_ready_i = 1'b0;
        frame_start("f4a");
        for (int k = 1; k <= 5; k++)
            post($sformatf("f4a_p%0d", k), k == 4, 1'b0, {k >= 4, 1'b0});
        send_bytes("f4a_part", 2, 1'b0, 1'b0);
        frame_start("f4b");
        for (int k = 1; k <= 8; k++)
            post($sformatf("f4b_p%0d", k), k % 4 == 0, 1'b0, {k >= 4, k == 8});
        chk("f4b_flush", 16'({sample_en_o, flush_o, busy_o}), 16'b111);
`ifdef DEMOD_CTRL_STATS_EN
        chk("stats_frames", frame_cnt_o, 16'd3);
        chk("stats_ovr", ovr_cnt_o, 16'd2);
`endif

        // asynchronous reset in the middle of FLUSH
        #2 rst = 1'b1;
        #1 chk("rst_async", 16'(outs), 16'd0);
`ifdef DEMOD_CTRL_STATS_EN
        chk("stats_rst", frame_cnt_o | ovr_cnt_o, 16'd0);
`endif
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_%0d", i), 16'({sample_en_o, busy_o}), 16'd0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
